// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory signal bundle for the multi-cycle 16-bit CPU.
// CU_PERF_COUNTERS_EN adds the PERF_W parameter and the cycle/retire counter signals.
interface multicycle_control_unit_if #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 2
`ifdef CU_PERF_COUNTERS_EN
  , parameter int unsigned PERF_W = 16
`endif
);
  logic                enable;
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;
  logic                instr_req;
  logic                ir_write;
  logic                pc_write;
  logic                pc_branch;
  logic                mem_read;
  logic                mem_write;
  logic                reg_write;
  logic                reg_dst;
  logic                alu_src;
  logic                mem_to_reg;
  logic [ALUOP_W-1:0]  alu_op;
  logic                illegal;
  logic [2:0]          state;
`ifdef CU_PERF_COUNTERS_EN
  logic [PERF_W-1:0]   cycle_cnt;
  logic [PERF_W-1:0]   retire_cnt;
`endif

  modport master (
    input  enable, opcode, zero, mem_ready,
    output instr_req, ir_write, pc_write, pc_branch, mem_read, mem_write,
    output reg_write, reg_dst, alu_src, mem_to_reg, alu_op, illegal, state
`ifdef CU_PERF_COUNTERS_EN
    , output cycle_cnt, retire_cnt
`endif
  );

  modport slave (
    output enable, opcode, zero, mem_ready,
    input  instr_req, ir_write, pc_write, pc_branch, mem_read, mem_write,
    input  reg_write, reg_dst, alu_src, mem_to_reg, alu_op, illegal, state
`ifdef CU_PERF_COUNTERS_EN
    , input cycle_cnt, retire_cnt
`endif
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with illegal-opcode trap.
// Define CU_PERF_COUNTERS_EN to add the cycle_cnt/retire_cnt performance counters.
module multicycle_control_unit #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 2
`ifdef CU_PERF_COUNTERS_EN
  , parameter int unsigned PERF_W = 16
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd7
  } state_e;

  typedef enum logic [2:0] {ClsR, ClsI, ClsLw, ClsSw, ClsBeq} cls_e;

  state_e state_q;
  cls_e   cls_q;

  logic opcode_hi;
  generate
    if (OPCODE_W > 4) begin : g_hi
      assign opcode_hi = |bus.opcode[OPCODE_W-1:4];
    end else begin : g_no_hi
      assign opcode_hi = 1'b0;
    end
  endgenerate

  cls_e dec_cls;
  logic dec_ok;
  always_comb begin
    dec_cls = ClsR;
    dec_ok  = 1'b1;
    case (bus.opcode[3:0])
      4'b0000, 4'b0001, 4'b0010: dec_cls = ClsR;
      4'b1001, 4'b1010, 4'b1011: dec_cls = ClsI;
      4'b1100:                   dec_cls = ClsLw;
      4'b1101:                   dec_cls = ClsSw;
      4'b1111:                   dec_cls = ClsBeq;
      default:                   dec_ok  = 1'b0;
    endcase
    if (opcode_hi) dec_ok = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      cls_q   <= ClsR;
    end else begin
      case (state_q)
        StFetch:  if (bus.enable && bus.mem_ready) state_q <= StDecode;
        StDecode: begin
          if (dec_ok) begin
            cls_q   <= dec_cls;
            state_q <= StExec;
          end else begin
            state_q <= StTrap;
          end
        end
        StExec: begin
          case (cls_q)
            ClsBeq:       state_q <= StFetch;
            ClsLw, ClsSw: state_q <= StMem;
            default:      state_q <= StWb;
          endcase
        end
        StMem:    if (bus.mem_ready) state_q <= (cls_q == ClsLw) ? StWb : StFetch;
        StWb:     state_q <= StFetch;
        StTrap:   state_q <= StTrap;
        default:  state_q <= StFetch;
      endcase
    end
  end

  logic       cls_alu_src;
  logic [1:0] cls_alu_op;
  always_comb begin
    cls_alu_src = 1'b0;
    cls_alu_op  = 2'b00;
    case (cls_q)
      ClsR:         begin cls_alu_src = 1'b0; cls_alu_op = 2'b10; end
      ClsI:         begin cls_alu_src = 1'b1; cls_alu_op = 2'b11; end
      ClsLw, ClsSw: begin cls_alu_src = 1'b1; cls_alu_op = 2'b00; end
      ClsBeq:       begin cls_alu_src = 1'b0; cls_alu_op = 2'b01; end
      default:      ;
    endcase
  end

  logic       instr_req_c, ir_write_c, pc_write_c, pc_branch_c, mem_read_c, mem_write_c;
  logic       reg_write_c, reg_dst_c, alu_src_c, mem_to_reg_c, illegal_c;
  logic [1:0] alu_op_c;
  always_comb begin
    instr_req_c  = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_branch_c  = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    alu_src_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    illegal_c    = 1'b0;
    alu_op_c     = 2'b00;
    case (state_q)
      StFetch: begin
        instr_req_c = bus.enable;
        ir_write_c  = bus.enable & bus.mem_ready;
        pc_write_c  = bus.enable & bus.mem_ready;
      end
      StExec: begin
        alu_src_c   = cls_alu_src;
        alu_op_c    = cls_alu_op;
        pc_branch_c = (cls_q == ClsBeq) & bus.zero;
      end
      StMem: begin
        alu_src_c   = cls_alu_src;
        alu_op_c    = cls_alu_op;
        mem_read_c  = (cls_q == ClsLw);
        mem_write_c = (cls_q == ClsSw);
      end
      StWb: begin
        alu_src_c    = cls_alu_src;
        alu_op_c     = cls_alu_op;
        reg_write_c  = 1'b1;
        reg_dst_c    = (cls_q == ClsR);
        mem_to_reg_c = (cls_q == ClsLw);
      end
      StTrap:  illegal_c = 1'b1;
      default: ;
    endcase
  end

  // Outputs drop the instant reset rises, even while enable/mem_ready are still high.
  assign bus.instr_req  = instr_req_c  & ~reset;
  assign bus.ir_write   = ir_write_c   & ~reset;
  assign bus.pc_write   = pc_write_c   & ~reset;
  assign bus.pc_branch  = pc_branch_c  & ~reset;
  assign bus.mem_read   = mem_read_c   & ~reset;
  assign bus.mem_write  = mem_write_c  & ~reset;
  assign bus.reg_write  = reg_write_c  & ~reset;
  assign bus.reg_dst    = reg_dst_c    & ~reset;
  assign bus.alu_src    = alu_src_c    & ~reset;
  assign bus.mem_to_reg = mem_to_reg_c & ~reset;
  assign bus.illegal    = illegal_c    & ~reset;
  assign bus.alu_op     = ALUOP_W'(alu_op_c & {2{~reset}});
  assign bus.state      = state_q;

`ifdef CU_PERF_COUNTERS_EN
  logic [PERF_W-1:0] cycle_q, retire_q;
  logic              counting, retiring;

  assign counting = !((state_q == StFetch && !bus.enable) || state_q == StTrap);
  assign retiring = (state_q == StWb)
                  || (state_q == StMem && cls_q == ClsSw && bus.mem_ready)
                  || (state_q == StExec && cls_q == ClsBeq);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      if (counting) cycle_q  <= cycle_q + PERF_W'(1);
      if (retiring) retire_q <= retire_q + PERF_W'(1);
    end
  end

  assign bus.cycle_cnt  = cycle_q;
  assign bus.retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed per-cycle vector bench for multicycle_control_unit, plus trap/reset/perf sequences.
module tb_multicycle_control_unit;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd7;

  // {instr_req,ir_write,pc_write,pc_branch, mem_read,mem_write,
  //  reg_write,reg_dst,alu_src,mem_to_reg, alu_op[1:0], illegal}
  localparam logic [12:0] C_IDLE = 13'b0000_00_0000_00_0;
  localparam logic [12:0] C_FW   = 13'b1000_00_0000_00_0;
  localparam logic [12:0] C_FD   = 13'b1110_00_0000_00_0;
  localparam logic [12:0] C_EXR  = 13'b0000_00_0000_10_0;
  localparam logic [12:0] C_WBR  = 13'b0000_00_1100_10_0;
  localparam logic [12:0] C_EXI  = 13'b0000_00_0010_11_0;
  localparam logic [12:0] C_WBI  = 13'b0000_00_1010_11_0;
  localparam logic [12:0] C_EXL  = 13'b0000_00_0010_00_0;
  localparam logic [12:0] C_MEML = 13'b0000_10_0010_00_0;
  localparam logic [12:0] C_MEMS = 13'b0000_01_0010_00_0;
  localparam logic [12:0] C_WBL  = 13'b0000_00_1011_00_0;
  localparam logic [12:0] C_EXB1 = 13'b0001_00_0000_01_0;
  localparam logic [12:0] C_EXB0 = 13'b0000_00_0000_01_0;
  localparam logic [12:0] C_TRAP = 13'b0000_00_0000_00_1;

  typedef struct {
    logic       en;
    logic [4:0] op;
    logic       z;
    logic       rdy;
    logic [2:0] st;
    logic [12:0] ctl;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t vecs[$];
  vec_t add_seq[$];

  multicycle_control_unit_if #(
    .OPCODE_W(5),
    .ALUOP_W (2)
`ifdef CU_PERF_COUNTERS_EN
    , .PERF_W(4)
`endif
  ) bus ();

  multicycle_control_unit #(
    .OPCODE_W(5),
    .ALUOP_W (2)
`ifdef CU_PERF_COUNTERS_EN
    , .PERF_W(4)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] observed();
    return {bus.state, bus.instr_req, bus.ir_write, bus.pc_write, bus.pc_branch,
            bus.mem_read, bus.mem_write, bus.reg_write, bus.reg_dst, bus.alu_src,
            bus.mem_to_reg, bus.alu_op, bus.illegal};
  endfunction

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic add(input logic en, input logic [4:0] op, input logic z, input logic rdy,
                     input logic [2:0] st, input logic [12:0] ctl);
    vec_t v;
    v.en = en; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, check mid-cycle, then advance past the next rising edge.
  task automatic step(input vec_t v, input string nm);
    bus.enable    = v.en;
    bus.opcode    = v.op;
    bus.zero      = v.z;
    bus.mem_ready = v.rdy;
    @(negedge clk);
    check(nm, observed(), {v.st, v.ctl});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.enable = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_add(input string nm);
    foreach (add_seq[i]) step(add_seq[i], $sformatf("%s_%0d", nm, i));
  endtask

  initial begin
    vec_t v;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.enable = 1'b1; bus.opcode = 5'h01; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    #1 reset = 1'b1;
    #1 check("reset_outputs", observed(), {S_F, C_IDLE});
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ADD, zero wait; mem_ready in DECODE is spurious
    add(1'b1, 5'h01, 1'b0, 1'b1, S_F, C_FD);
    add(1'b1, 5'h01, 1'b0, 1'b1, S_D, C_IDLE);
    add(1'b1, 5'h01, 1'b0, 1'b1, S_E, C_EXR);
    add(1'b1, 5'h01, 1'b0, 1'b1, S_W, C_WBR);
    for (int i = 0; i < 4; i++) add_seq.push_back(vecs[i]);
    // LW: one fetch wait, three MEM waits
    add(1'b1, 5'h0C, 1'b0, 1'b0, S_F, C_FW);
    add(1'b1, 5'h0C, 1'b0, 1'b1, S_F, C_FD);
    add(1'b1, 5'h0C, 1'b0, 1'b0, S_D, C_IDLE);
    add(1'b1, 5'h0C, 1'b0, 1'b0, S_E, C_EXL);
    add(1'b1, 5'h0C, 1'b0, 1'b0, S_M, C_MEML);
    add(1'b1, 5'h0C, 1'b0, 1'b0, S_M, C_MEML);
    add(1'b1, 5'h0C, 1'b0, 1'b0, S_M, C_MEML);
    add(1'b1, 5'h0C, 1'b0, 1'b1, S_M, C_MEML);
    add(1'b1, 5'h0C, 1'b0, 1'b0, S_W, C_WBL);
    // BEQ taken then not taken
    add(1'b1, 5'h0F, 1'b1, 1'b1, S_F, C_FD);
    add(1'b1, 5'h0F, 1'b1, 1'b0, S_D, C_IDLE);
    add(1'b1, 5'h0F, 1'b1, 1'b0, S_E, C_EXB1);
    add(1'b1, 5'h0F, 1'b0, 1'b1, S_F, C_FD);
    add(1'b1, 5'h0F, 1'b0, 1'b0, S_D, C_IDLE);
    add(1'b1, 5'h0F, 1'b0, 1'b0, S_E, C_EXB0);
    // I-type with enable dropped mid-instruction; pauses at FETCH
    add(1'b1, 5'h09, 1'b0, 1'b1, S_F, C_FD);
    add(1'b0, 5'h09, 1'b0, 1'b0, S_D, C_IDLE);
    add(1'b0, 5'h09, 1'b0, 1'b0, S_E, C_EXI);
    add(1'b0, 5'h09, 1'b0, 1'b0, S_W, C_WBI);
    add(1'b0, 5'h09, 1'b0, 1'b1, S_F, C_IDLE);
    add(1'b0, 5'h09, 1'b0, 1'b1, S_F, C_IDLE);
    // SW, zero wait
    add(1'b1, 5'h0D, 1'b0, 1'b1, S_F, C_FD);
    add(1'b1, 5'h0D, 1'b0, 1'b1, S_D, C_IDLE);
    add(1'b1, 5'h0D, 1'b0, 1'b1, S_E, C_EXL);
    add(1'b1, 5'h0D, 1'b0, 1'b1, S_M, C_MEMS);
    add(1'b0, 5'h0D, 1'b0, 1'b0, S_F, C_IDLE);

    foreach (vecs[i]) step(vecs[i], $sformatf("row%0d", i));

    // Opcode 0111 traps and stays trapped regardless of inputs
    v.en = 1'b1; v.op = 5'h07; v.z = 1'b0; v.rdy = 1'b1; v.st = S_F; v.ctl = C_FD;
    step(v, "trap_fetch");
    v.st = S_D; v.ctl = C_IDLE;
    step(v, "trap_decode");
    for (int i = 0; i < 20; i++) begin
      v.en  = 1'($urandom_range(0, 1));
      v.op  = 5'($urandom_range(0, 31));
      v.z   = 1'($urandom_range(0, 1));
      v.rdy = 1'($urandom_range(0, 1));
      v.st  = S_T;
      v.ctl = C_TRAP;
      step(v, $sformatf("trap_hold%0d", i));
    end
    bus.enable = 1'b1;
    bus.mem_ready = 1'b1;
    #2 reset = 1'b1;
    #1 check("trap_async_reset", observed(), {S_F, C_IDLE});
    @(posedge clk);
    #1 reset = 1'b0;
    v.en = 1'b0; v.rdy = 1'b0; v.st = S_F; v.ctl = C_IDLE;
    step(v, "trap_cleared");

    // Upper opcode bit set is illegal even with a legal low nibble
    v.en = 1'b1; v.op = 5'h11; v.rdy = 1'b1; v.st = S_F; v.ctl = C_FD;
    step(v, "hi_fetch");
    v.st = S_D; v.ctl = C_IDLE;
    step(v, "hi_decode");
    v.st = S_T; v.ctl = C_TRAP;
    step(v, "hi_trap");
    do_reset();

    // SW abandoned by an asynchronous reset in MEM
    v.en = 1'b1; v.op = 5'h0D; v.z = 1'b0; v.rdy = 1'b1; v.st = S_F; v.ctl = C_FD;
    step(v, "swr_fetch");
    v.rdy = 1'b0; v.st = S_D; v.ctl = C_IDLE;
    step(v, "swr_decode");
    v.st = S_E; v.ctl = C_EXL;
    step(v, "swr_exec");
    v.st = S_M; v.ctl = C_MEMS;
    step(v, "swr_mem");
    #2 check("swr_mem_held", observed(), {S_M, C_MEMS});
    bus.mem_ready = 1'b1;
    reset = 1'b1;
    #1 check("swr_async_reset", observed(), {S_F, C_IDLE});
    @(posedge clk);
    #1 reset = 1'b0;
    run_add("swr_restart");

`ifdef CU_PERF_COUNTERS_EN
    do_reset();
    check("perf_reset", {8'h00, bus.cycle_cnt, bus.retire_cnt}, 16'h0000);
    for (int i = 0; i < 5; i++) run_add($sformatf("perf_add%0d", i));
    bus.enable = 1'b0;
    @(negedge clk);
    check("perf_counts", {8'h00, bus.cycle_cnt, bus.retire_cnt}, {8'h00, 4'd4, 4'd5});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
